// File: rtl/serial_mag_comparator.sv
// Digit-serial MSB-first magnitude comparator with start/ready/done handshake.
// Optional two's-complement ordering is enabled by defining CMP_SIGNED_EN (adds is_signed).
module serial_mag_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             ready,
    output logic             done,
    output logic [1:0]       r
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] NMAX = CW'(N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]    cnt;
    logic             nz, decided, sgn;
    logic [1:0]       first_code;

    logic [DIGIT-1:0] raw_a, raw_b, dig_a, dig_b;
    logic             flip, differ, nz_next;
    logic [1:0]       code_now, final_code;

`ifndef CMP_SIGNED_EN
    assign sgn = 1'b0;
`endif

    // Sign flip applies only to the top digit; nonzero tracking uses the raw bits.
    always_comb begin
        raw_a = a_sh[WIDTH-1 -: DIGIT];
        raw_b = b_sh[WIDTH-1 -: DIGIT];
        flip  = sgn && (cnt == '0);
        dig_a = raw_a;
        dig_b = raw_b;
        dig_a[DIGIT-1] = raw_a[DIGIT-1] ^ flip;
        dig_b[DIGIT-1] = raw_b[DIGIT-1] ^ flip;
        differ     = (dig_a != dig_b);
        code_now   = (dig_a > dig_b) ? 2'b01 : 2'b10;
        nz_next    = nz | (|raw_a);
        final_code = decided ? first_code :
                     differ  ? code_now   :
                     nz_next ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            r          <= 2'b00;
            a_sh       <= '0;
            b_sh       <= '0;
            cnt        <= '0;
            nz         <= 1'b0;
            decided    <= 1'b0;
            first_code <= 2'b00;
`ifdef CMP_SIGNED_EN
            sgn        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_RUN;
                        ready   <= 1'b0;
                        a_sh    <= a;
                        b_sh    <= b;
                        cnt     <= '0;
                        nz      <= 1'b0;
                        decided <= 1'b0;
`ifdef CMP_SIGNED_EN
                        sgn     <= is_signed;
`endif
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh << DIGIT;
                    b_sh <= b_sh << DIGIT;
                    nz   <= nz_next;
                    if (cnt != NMAX)
                        cnt <= cnt + 1'b1;
                    // Only the first differing digit is remembered; later ones never override.
                    if (differ && !decided) begin
                        decided    <= 1'b1;
                        first_code <= code_now;
                    end
                    if (((EARLY_EXIT != 0) && differ && !decided) || cnt == LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        r     <= final_code;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
